// File: rtl/mr_databus_pkg.sv
// Shared types and defaults for the registered memory-read data bus selector.
// Imported by the slice mux and by the sequencer top.
package mr_databus_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NSRC    = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Bit width needed to index n values, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mr_databus_sel.sv
// N:1 slice mux over the flattened source bus; yields zero data and no ready
// when the index names no existing source.
module mr_databus_sel
  import mr_databus_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NSRC  = DEF_NSRC,
  localparam int SELW  = clog2_min1(NSRC)
) (
  input  logic [SELW-1:0]       idx,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [NSRC-1:0]       in_rdy,
  output logic [WIDTH-1:0]      data,
  output logic                  rdy,
  output logic                  hit
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch for the miss case.
  always_comb begin
    data = '0;
    rdy  = 1'b0;
    hit  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (idx == SELW'(k)) begin
        data = in_data[k*WIDTH +: WIDTH];
        rdy  = in_rdy[k];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mr_databus_seq.sv
// Registered read-data bus sequencer: steers one of NSRC sources onto OUT0
// under a request/valid handshake, waiting on slow sources with a bounded timeout.
module mr_databus_seq
  import mr_databus_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NSRC    = DEF_NSRC,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int SELW    = clog2_min1(NSRC),
  localparam int CNTW    = clog2_min1(TIMEOUT + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ,
  input  logic [SELW-1:0]       SEL,
  input  logic [NSRC*WIDTH-1:0] IN_DATA,
  input  logic [NSRC-1:0]       IN_RDY,
  output logic [WIDTH-1:0]      OUT0,
  output logic                  VALID,
  output logic                  ERR,
  output logic                  BUSY
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  req_data, wait_data;
  logic              req_rdy, req_hit;
  logic              wait_rdy, wait_hit;
  logic              wait_ready;
  logic              timeout_hit;

  // Two muxes: the live SEL is only meaningful in IDLE, the latched one in WAIT.
  mr_databus_sel #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_sel_req (
    .idx     (SEL),
    .in_data (IN_DATA),
    .in_rdy  (IN_RDY),
    .data    (req_data),
    .rdy     (req_rdy),
    .hit     (req_hit)
  );

  mr_databus_sel #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_sel_wait (
    .idx     (sel_q),
    .in_data (IN_DATA),
    .in_rdy  (IN_RDY),
    .data    (wait_data),
    .rdy     (wait_rdy),
    .hit     (wait_hit)
  );

  // sel_q is only ever loaded with an in-range index; the hit term is a guard.
  assign wait_ready  = wait_rdy && wait_hit;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ && req_hit && !req_rdy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_ready || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; ready takes priority over a coincident timeout.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (!req_hit || req_rdy) begin
            // An out-of-range index reads as zero straight from the mux.
            out_d   = req_data;
            valid_d = 1'b1;
          end else begin
            sel_d = SEL;
            cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        if (wait_ready) begin
          out_d   = wait_data;
          valid_d = 1'b1;
        end else if (timeout_hit) begin
          out_d   = '0;
          valid_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT0  = out_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign BUSY  = (state_q == ST_WAIT);

endmodule

// File: doc/mr_databus_seq.md
Name: mr_databus_seq

Overview:
Parametrised, registered successor to the memory-read data bus selector. It steers one of NSRC read sources (register file, ROM/RAM, IO, …) onto the read data bus under a request/valid handshake. It waits on a per-source ready for slow sources and bounds each wait with a timeout that returns zero plus an error flag. It sits between the address/source decoder and the CPU read-data latch.

Parameters:
WIDTH, 16, data bus width in bits
NSRC, 4, number of read sources (≥2)
TIMEOUT, 15, maximum WAIT cycles before abort; 0 disables the timeout
SELW (localparam), $clog2(NSRC), select width
CNTW (localparam), $clog2(TIMEOUT+1) (min 1), wait counter width

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous active-low reset
REQ  input  1  read request, sampled only in IDLE
SEL  input  SELW  source index, latched with an accepted REQ
IN_DATA  input  NSRC*WIDTH  flattened source data; source k occupies bits [k*WIDTH +: WIDTH]
IN_RDY  input  NSRC  per-source data-ready
OUT0  output  WIDTH  registered read data
VALID  output  1  one-cycle pulse: OUT0 updated this cycle
ERR  output  1  one-cycle pulse coincident with VALID: timeout abort
BUSY  output  1  high while in WAIT

Behaviour:
- Reset, asynchronous on RESET_N low: state IDLE, OUT0=0, VALID=0, ERR=0, BUSY=0, sel_q=0, wait counter=0.
- States: IDLE and WAIT.
- VALID and ERR default to 0 every cycle; each is set for exactly one cycle on capture.
- IDLE, REQ=1, SEL≥NSRC: capture zero (OUT0<=0), VALID=1 next cycle, ERR=0, stay IDLE. This replaces the old zero source.
- IDLE, REQ=1, SEL<NSRC, IN_RDY[SEL]=1: capture IN_DATA slice SEL into OUT0, VALID=1 next cycle, stay IDLE. Latency is 1 cycle.
- IDLE, REQ=1, SEL<NSRC, IN_RDY[SEL]=0: latch sel_q=SEL, clear counter, go to WAIT. BUSY=1 from the next cycle.
- IDLE, REQ=0: hold. OUT0 keeps its last captured value.
- WAIT, IN_RDY[sel_q]=1: capture slice sel_q, VALID=1, go to IDLE.
- WAIT, not ready, TIMEOUT≠0 and counter==TIMEOUT-1: OUT0<=0, VALID=1, ERR=1, go to IDLE.
- WAIT, otherwise: counter+1, stay in WAIT.
- Ready and timeout in the same cycle: ready wins, ERR=0.
- REQ and SEL are ignored while in WAIT. A request raised during WAIT is lost; the requester must hold REQ until BUSY=0.
- Back-to-back operation: a REQ in the same cycle as VALID (state IDLE) is accepted. With ready sources, one VALID per cycle is sustainable.
- TIMEOUT=0: WAIT lasts indefinitely until ready.
- Reset asserted in WAIT: transaction aborted, no VALID or ERR.
- IN_DATA and IN_RDY of unselected sources have no effect.

Decomposition:
- Shared package mr_databus_pkg holds:
  - state enum (ST_IDLE, ST_WAIT)
  - default WIDTH/NSRC/TIMEOUT constants
  - a clog2-with-min-1 helper
- One natural combinational sub-module, mr_databus_sel:
  - WIDTH/NSRC N:1 slice mux returning zero for index≥NSRC
  - also outputs the selected IN_RDY bit
  - instantiated twice: once on SEL for IDLE, once on sel_q for WAIT

Test Plan:
- Reset mid-WAIT (SEL=2, IN_RDY=0), release RESET_N → OUT0=0, VALID/ERR/BUSY=0, no spurious VALID after release.
- Fast read: REQ=1, SEL=0, IN_RDY=4'b0001, slice0=16'hA5A5 at cycle 0 → OUT0=16'hA5A5, VALID=1, BUSY never high, all at cycle 1.
- Slow read: REQ at cycle 0, SEL=2, IN_RDY[2] rises at cycle 4 with slice2=16'h1234 → BUSY=1 in cycles 1–4, OUT0=16'h1234 and VALID at cycle 5, ERR=0.
- Timeout: TIMEOUT=15, SEL=3, IN_RDY[3] never set → VALID=ERR=1 and OUT0=0 exactly 16 cycles after the REQ cycle; then IDLE. Repeat with IN_RDY[3] rising on the final wait cycle → data returned, ERR=0.
- Out-of-range select: NSRC=3, SEL=3 → OUT0=0, VALID=1, ERR=0 at latency 1.
- Back-to-back: REQ held high with SEL=0,1,0,1 and both ready → VALID every cycle, OUT0 tracks each slice in order.
